// File: rtl/input_controller.sv
// input_controller: sync/debounce/edge-detect buttons {r,u,l} (btn_state, press) into frame-committed lane/hoffset and a held jump_req.
module input_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH = 20,
  parameter int LANE_HOFFSET = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        frame_tick,
  input  logic        jump_ack,
  output logic [2:0]  btn_state,
  output logic [2:0]  press,
  output logic [1:0]  lane,
  output logic [11:0] hoffset,
  output logic        jump_req
);
  typedef enum logic [1:0] {NONE, LEFT, RIGHT} pend_t;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0] OFF_POS = 12'(LANE_HOFFSET);
  localparam logic [11:0] OFF_NEG = 12'(-LANE_HOFFSET);
  logic [2:0] r_s1, r_s2, r_state, r_state_d, r_press;
  logic [CNT_WIDTH-1:0] r_cnt [3];
  pend_t r_pend, w_pend_nx, w_move;
  logic [1:0] r_lane, w_lane_nx;
  logic [11:0] r_hoff;
  logic r_jump;
  always_comb begin
    w_move = r_press[0] ? LEFT : RIGHT;
    w_pend_nx = (r_press[0] ^ r_press[2]) ? w_move : frame_tick ? NONE : r_pend;
    w_lane_nx = (r_pend == LEFT && r_lane != 2'd0) ? r_lane - 2'd1 :
                (r_pend == RIGHT && r_lane != 2'd2) ? r_lane + 2'd1 : r_lane;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_state <= '0;
      r_state_d <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      r_pend <= NONE;
      r_lane <= 2'd1;
      r_hoff <= '0;
      r_jump <= 1'b0;
    end else begin
      r_s1 <= {btn_r, btn_u, btn_l};
      r_s2 <= r_s1;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= (r_s2[i] == r_state[i] || r_cnt[i] == CNT_LAST) ? '0 : r_cnt[i] + 1'b1;
        if (r_s2[i] != r_state[i] && r_cnt[i] == CNT_LAST) r_state[i] <= r_s2[i];
      end
      r_state_d <= r_state;
      r_press <= r_state & ~r_state_d;
      r_pend <= w_pend_nx;
      if (frame_tick) begin
        r_lane <= w_lane_nx;
        r_hoff <= (w_lane_nx == 2'd0) ? OFF_NEG : (w_lane_nx == 2'd2) ? OFF_POS : '0;
      end
      r_jump <= r_press[1] | (r_jump & ~jump_ack);
    end
  end
  assign btn_state = r_state;
  assign press = r_press;
  assign lane = r_lane;
  assign hoffset = r_hoff;
  assign jump_req = r_jump;
endmodule
